// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select indices,
// sequencer state encoding and control bundles.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_SHL  = 5'h05;
  localparam logic [4:0] OP_ROR  = 5'h06;
  localparam logic [4:0] OP_ROL  = 5'h07;
  localparam logic [4:0] OP_MUL  = 5'h08;
  localparam logic [4:0] OP_DIV  = 5'h09;
  localparam logic [4:0] OP_NEG  = 5'h0A;
  localparam logic [4:0] OP_NOT  = 5'h0B;
  localparam logic [4:0] OP_MFHI = 5'h0C;
  localparam logic [4:0] OP_MFLO = 5'h0D;
  localparam logic [4:0] OP_NOP  = 5'h1E;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam int ALU_W = 12;
  localparam int A_AND = 0;
  localparam int A_OR  = 1;
  localparam int A_ADD = 2;
  localparam int A_SUB = 3;
  localparam int A_MUL = 4;
  localparam int A_DIV = 5;
  localparam int A_SHR = 6;
  localparam int A_SHL = 7;
  localparam int A_ROR = 8;
  localparam int A_ROL = 9;
  localparam int A_NEG = 10;
  localparam int A_NOT = 11;

  typedef logic [ALU_W-1:0] alu_t;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_unary;
    logic is_muldiv;
    logic is_mfhi;
    logic is_mflo;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

  typedef struct packed {
    logic pcout, mdrout, zhiout, zlowout, hiout, loout;
    logic pcin, marin, mdrin, irin, yin, zin;
    logic hiin, loin, rin;
    logic gra, grb, grc, rout;
    logic incpc, read, run, illegal;
  } ctl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction and memory
// status in, bus/load strobes and ALU select out.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic [31:0] ir;
  logic memready;
  logic pcout, mdrout, zhiout, zlowout, hiout, loout;
  logic pcin, marin, mdrin, irin, yin, zin;
  logic hiin, loin, rin;
  logic gra, grb, grc, rout;
  logic incpc, read, run, illegal;
  alu_t alu;

  modport master (
    input  ir, memready,
    output pcout, mdrout, zhiout, zlowout, hiout, loout,
    output pcin, marin, mdrin, irin, yin, zin,
    output hiin, loin, rin, gra, grb, grc, rout,
    output incpc, read, run, illegal, alu
  );

  modport slave (
    output ir, memready,
    input  pcout, mdrout, zhiout, zlowout, hiout, loout,
    input  pcin, marin, mdrin, irin, yin, zin,
    input  hiin, loin, rin, gra, grb, grc, rout,
    input  incpc, read, run, illegal, alu
  );
endinterface

// File: rtl/op_decode.sv
// Opcode decode: one-hot ALU select plus class flags
// that steer the sequencer's execute phase.
module op_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output alu_t       alu,
  output op_class_t  cls
);

  always_comb begin
    alu = '0;
    cls = '0;
    unique case (opcode)
      OP_ADD:  alu[A_ADD] = 1'b1;
      OP_SUB:  alu[A_SUB] = 1'b1;
      OP_AND:  alu[A_AND] = 1'b1;
      OP_OR:   alu[A_OR]  = 1'b1;
      OP_SHR:  alu[A_SHR] = 1'b1;
      OP_SHL:  alu[A_SHL] = 1'b1;
      OP_ROR:  alu[A_ROR] = 1'b1;
      OP_ROL:  alu[A_ROL] = 1'b1;
      OP_MUL:  alu[A_MUL] = 1'b1;
      OP_DIV:  alu[A_DIV] = 1'b1;
      OP_NEG:  alu[A_NEG] = 1'b1;
      OP_NOT:  alu[A_NOT] = 1'b1;
      OP_MFHI: cls.is_mfhi = 1'b1;
      OP_MFLO: cls.is_mflo = 1'b1;
      OP_NOP:  cls.is_nop = 1'b1;
      OP_HALT: cls.is_halt = 1'b1;
      default: cls.is_illegal = 1'b1;
    endcase
    cls.is_alu    = |alu;
    cls.is_unary  = alu[A_NEG] | alu[A_NOT];
    cls.is_muldiv = alu[A_MUL] | alu[A_DIV];
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch T0-T2, execute
// T3-T6, HALT parks until clear.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic clock,
  input  logic clear,
  control_sequencer_if.master bus
);

  state_t    state, nxt;
  alu_t      alu_dec, alu;
  op_class_t cls;
  ctl_t      ctl;

  op_decode u_dec (
    .opcode (bus.ir[31:27]),
    .alu    (alu_dec),
    .cls    (cls)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    ctl = '0;
    alu = '0;
    ctl.run = 1'b1;
    case (state)
      S_IDLE: nxt = S_T0;
      S_T0: begin
        ctl.pcout = 1'b1;
        ctl.marin = 1'b1;
        ctl.incpc = 1'b1;
        nxt = S_T1;
      end
      S_T1: begin
        ctl.read  = 1'b1;
        ctl.mdrin = 1'b1;
        if (bus.memready) nxt = S_T2;
      end
      S_T2: begin
        ctl.mdrout = 1'b1;
        ctl.irin   = 1'b1;
        nxt = S_T3;
      end
      S_T3: begin
        nxt = S_T0;
        unique case (1'b1)
          cls.is_alu: begin
            ctl.grb  = 1'b1;
            ctl.rout = 1'b1;
            ctl.yin  = 1'b1;
            nxt = S_T4;
          end
          cls.is_mfhi: begin
            ctl.hiout = 1'b1;
            ctl.gra   = 1'b1;
            ctl.rin   = 1'b1;
          end
          cls.is_mflo: begin
            ctl.loout = 1'b1;
            ctl.gra   = 1'b1;
            ctl.rin   = 1'b1;
          end
          cls.is_halt:    nxt = S_HALT;
          cls.is_illegal: ctl.illegal = 1'b1;
          cls.is_nop:     nxt = S_T0;
          default:        nxt = S_T0;
        endcase
      end
      S_T4: begin
        // unary ops take their operand from rb, others from rc
        ctl.grb  = cls.is_unary;
        ctl.grc  = ~cls.is_unary;
        ctl.rout = 1'b1;
        ctl.zin  = 1'b1;
        alu = alu_dec;
        nxt = S_T5;
      end
      S_T5: begin
        ctl.zlowout = 1'b1;
        if (cls.is_muldiv) begin
          ctl.loin = 1'b1;
          nxt = S_T6;
        end else begin
          ctl.gra = 1'b1;
          ctl.rin = 1'b1;
          nxt = S_T0;
        end
      end
      S_T6: begin
        ctl.zhiout = 1'b1;
        ctl.hiin   = 1'b1;
        nxt = S_T0;
      end
      S_HALT: begin
        ctl.run = 1'b0;
        nxt = S_HALT;
      end
      default: begin
        ctl.run = 1'b0;
        nxt = S_IDLE;
      end
    endcase
    // clear silences every output without waiting for an edge
    if (clear) begin
      ctl = '0;
      alu = '0;
    end
  end

  assign bus.pcout   = ctl.pcout;
  assign bus.mdrout  = ctl.mdrout;
  assign bus.zhiout  = ctl.zhiout;
  assign bus.zlowout = ctl.zlowout;
  assign bus.hiout   = ctl.hiout;
  assign bus.loout   = ctl.loout;
  assign bus.pcin    = ctl.pcin;
  assign bus.marin   = ctl.marin;
  assign bus.mdrin   = ctl.mdrin;
  assign bus.irin    = ctl.irin;
  assign bus.yin     = ctl.yin;
  assign bus.zin     = ctl.zin;
  assign bus.hiin    = ctl.hiin;
  assign bus.loin    = ctl.loin;
  assign bus.rin     = ctl.rin;
  assign bus.gra     = ctl.gra;
  assign bus.grb     = ctl.grb;
  assign bus.grc     = ctl.grc;
  assign bus.rout    = ctl.rout;
  assign bus.incpc   = ctl.incpc;
  assign bus.read    = ctl.read;
  assign bus.run     = ctl.run;
  assign bus.illegal = ctl.illegal;
  assign bus.alu     = alu;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle
// expected strobe words queued and checked at negedge.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic clock;
  logic clear;
  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [39:0] ONE     = 40'h1;
  localparam logic [39:0] PCOUT   = ONE << 0;
  localparam logic [39:0] MDROUT  = ONE << 1;
  localparam logic [39:0] ZHIOUT  = ONE << 2;
  localparam logic [39:0] ZLOWOUT = ONE << 3;
  localparam logic [39:0] HIOUT   = ONE << 4;
  localparam logic [39:0] MARIN   = ONE << 7;
  localparam logic [39:0] MDRIN   = ONE << 8;
  localparam logic [39:0] IRIN    = ONE << 9;
  localparam logic [39:0] YIN     = ONE << 10;
  localparam logic [39:0] ZIN     = ONE << 11;
  localparam logic [39:0] HIIN    = ONE << 12;
  localparam logic [39:0] LOIN    = ONE << 13;
  localparam logic [39:0] RIN     = ONE << 14;
  localparam logic [39:0] GRA     = ONE << 15;
  localparam logic [39:0] GRB     = ONE << 16;
  localparam logic [39:0] GRC     = ONE << 17;
  localparam logic [39:0] ROUT    = ONE << 18;
  localparam logic [39:0] INCPC   = ONE << 19;
  localparam logic [39:0] READ    = ONE << 20;
  localparam logic [39:0] RUN     = ONE << 21;
  localparam logic [39:0] ILLEGAL = ONE << 22;
  localparam logic [39:0] SRCS    = 40'h3F | ROUT;

  localparam logic [39:0] W_T0 = RUN | PCOUT | MARIN | INCPC;
  localparam logic [39:0] W_T1 = RUN | READ | MDRIN;
  localparam logic [39:0] W_T2 = RUN | MDROUT | IRIN;
  localparam logic [39:0] W_T3 = RUN | GRB | ROUT | YIN;
  localparam logic [39:0] W_WB = RUN | ZLOWOUT | GRA | RIN;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];
  string tag_q[$];

  function automatic logic [39:0] aluw(int idx);
    return ONE << (23 + idx);
  endfunction

  function automatic logic [39:0] pack();
    return {5'b0, bus.alu, bus.illegal, bus.run,
            bus.read, bus.incpc, bus.rout, bus.grc,
            bus.grb, bus.gra, bus.rin, bus.loin,
            bus.hiin, bus.zin, bus.yin, bus.irin,
            bus.mdrin, bus.marin, bus.pcin, bus.loout,
            bus.hiout, bus.zlowout, bus.zhiout,
            bus.mdrout, bus.pcout};
  endfunction

  task automatic chk(string tag, logic [39:0] got,
                     logic [39:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t",
               tag, got, want, $time);
    end
  endtask

  task automatic push(string t, logic [39:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic step(string t, logic [39:0] e);
    @(posedge clock);
    #1;
    push(t, e);
  endtask

  task automatic restart(logic [31:0] nir);
    @(negedge clock);
    #1 clear = 1'b1;
    bus.ir = nir;
    #1 chk("clear_async", pack(), 40'h0);
    @(posedge clock);
    #1 clear = 1'b0;
    push("idle", RUN);
  endtask

  task automatic fetch();
    step("t0", W_T0);
    step("t1", W_T1);
    step("t2", W_T2);
  endtask

  always @(negedge clock) begin
    logic [39:0] e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, pack(), e);
    end
    chk("one_bus",
        40'($countones(pack() & SRCS) <= 1), 40'h1);
    chk("one_alu", 40'($onehot0(bus.alu)), 40'h1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1;
    bus.memready = 1'b1;
    bus.ir = {5'h00, 4'd1, 4'd2, 4'd3, 15'd0};
    repeat (3) @(posedge clock);
    #1 chk("reset_outs", pack(), 40'h0);
    @(posedge clock);
    #1 clear = 1'b0;
    push("idle", RUN);

    // ADD r1,r2,r3 with memory always ready
    fetch();
    step("add_t3", W_T3);
    step("add_t4", RUN | GRC | ROUT | ZIN | aluw(A_ADD));
    step("add_t5", W_WB);
    step("add_t0", W_T0);

    // MUL with three wait cycles in T1
    restart({5'h08, 4'd4, 4'd5, 4'd6, 15'd0});
    bus.memready = 1'b0;
    step("mul_t0", W_T0);
    repeat (4) step("mul_t1", W_T1);
    bus.memready = 1'b1;
    step("mul_t2", W_T2);
    step("mul_t3", W_T3);
    step("mul_t4", RUN | GRC | ROUT | ZIN | aluw(A_MUL));
    step("mul_t5", RUN | ZLOWOUT | LOIN);
    step("mul_t6", RUN | ZHIOUT | HIIN);
    step("mul_t0", W_T0);

    // NEG uses rb as the operand in T4
    restart({5'h0A, 4'd7, 4'd8, 4'd0, 15'd0});
    fetch();
    step("neg_t3", W_T3);
    step("neg_t4", RUN | GRB | ROUT | ZIN | aluw(A_NEG));
    step("neg_t5", W_WB);
    step("neg_t0", W_T0);

    restart({5'h0C, 4'd2, 23'd0});
    fetch();
    step("mfhi_t3", RUN | HIOUT | GRA | RIN);
    step("mfhi_t0", W_T0);

    restart({5'h1E, 27'd0});
    fetch();
    step("nop_t3", RUN);
    step("nop_t0", W_T0);

    restart({5'h12, 27'd0});
    fetch();
    step("ill_t3", RUN | ILLEGAL);
    step("ill_t0", W_T0);

    restart({5'h1F, 27'd0});
    fetch();
    step("halt_t3", RUN);
    repeat (20) step("halt", 40'h0);
    restart({5'h00, 4'd1, 4'd2, 4'd3, 15'd0});
    step("post_halt_t0", W_T0);

    // clear lands in the middle of SUB's T4
    restart({5'h01, 4'd1, 4'd2, 4'd3, 15'd0});
    fetch();
    step("sub_t3", W_T3);
    step("sub_t4", RUN | GRC | ROUT | ZIN | aluw(A_SUB));
    restart({5'h00, 4'd1, 4'd2, 4'd3, 15'd0});
    step("post_clr_t0", W_T0);
    step("post_clr_t1", W_T1);

    repeat (3) @(posedge clock);
    #1;
    chk("drain", 40'(exp_q.size()), 40'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
